// File: rtl/alb_pkg.sv
// Shared definitions for the 4-bit ALB slice and its word sequencer.
package alb_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ANDN = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STEP  = 2'd2
  } seq_state_e;

  // Nibble add with carry-in; bit NIB_W is the carry-out.
  function automatic logic [NIB_W:0] nib_add(input logic [NIB_W-1:0] r,
                                             input logic [NIB_W-1:0] s,
                                             input logic             ci);
    nib_add = {1'b0, r} + {1'b0, s} + {{NIB_W{1'b0}}, ci};
  endfunction

endpackage

// File: rtl/alb.sv
// 4-bit ALB slice: inputs registered once, result/flags decoded combinationally.
module alb
  import alb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NIB_W-1:0] r_in,
  input  logic [NIB_W-1:0] s_in,
  input  logic             ci,
  input  logic [1:0]       i,
  output logic [NIB_W-1:0] f_alb_c,
  output logic             co_c,
  output logic             vo_c
);

  logic [NIB_W-1:0] r_q;
  logic [NIB_W-1:0] s_q;
  logic             ci_q;
  logic [1:0]       i_q;
  logic [NIB_W-1:0] s_eff;
  logic [NIB_W:0]   sum;

  // Input register stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q  <= '0;
      s_q  <= '0;
      ci_q <= 1'b0;
      i_q  <= OP_OR;
    end else begin
      r_q  <= r_in;
      s_q  <= s_in;
      ci_q <= ci;
      i_q  <= i;
    end
  end

  // Function decode; SUB is R + ~S + CI, logic ops report no carry/overflow.
  always_comb begin
    s_eff   = (i_q == OP_SUB) ? ~s_q : s_q;
    sum     = nib_add(r_q, s_eff, ci_q);
    f_alb_c = '0;
    co_c    = 1'b0;
    vo_c    = 1'b0;
    case (i_q)
      OP_OR:   f_alb_c = r_q | s_q;
      OP_ANDN: f_alb_c = ~r_q & s_q;
      default: begin
        f_alb_c = sum[NIB_W-1:0];
        co_c    = sum[NIB_W];
        vo_c    = (r_q[NIB_W-1] == s_eff[NIB_W-1]) &&
                  (sum[NIB_W-1] != r_q[NIB_W-1]);
      end
    endcase
  end

endmodule

// File: rtl/alb_word_seq.sv
// Word-wide operation sequencer driving one ALB slice nibble by nibble, LSN first.
module alb_word_seq
  import alb_pkg::*;
#(
  parameter int unsigned NIB = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [NIB_W*NIB-1:0] a_in,
  input  logic [NIB_W*NIB-1:0] b_in,
  input  logic                 ci_in,
  output logic                 ready,
  output logic                 done,
  output logic [NIB_W*NIB-1:0] result,
  output logic                 co,
  output logic                 vo,
  output logic                 no,
  output logic                 zo,
  output logic [NIB_W-1:0]     alb_r_in,
  output logic [NIB_W-1:0]     alb_s_in,
  output logic                 alb_ci,
  output logic [1:0]           alb_i,
  input  logic [NIB_W-1:0]     alb_f,
  input  logic                 alb_co,
  input  logic                 alb_vo
);

  localparam int unsigned W     = NIB_W * NIB;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  typedef logic [NIB-1:0][NIB_W-1:0] word_t;

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] nxt;
  logic [1:0]       op_q, op_d;
  word_t            a_q, a_d;
  word_t            b_q, b_d;
  logic             ci_q, ci_d;
  word_t            res_q, res_d;
  logic             zacc_q, zacc_d;
  logic             done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic             co_q, co_d;
  logic             vo_q, vo_d;
  logic             no_q, no_d;
  logic             zo_q, zo_d;

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign co     = co_q;
  assign vo     = vo_q;
  assign no     = no_q;
  assign zo     = zo_q;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= OP_OR;
      a_q      <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      res_q    <= '0;
      zacc_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      vo_q     <= 1'b0;
      no_q     <= 1'b0;
      zo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      res_q    <= res_d;
      zacc_q   <= zacc_d;
      done_q   <= done_d;
      result_q <= result_d;
      co_q     <= co_d;
      vo_q     <= vo_d;
      no_q     <= no_d;
      zo_q     <= zo_d;
    end
  end

  // Next-state, nibble mux and ALB drive; carry ripples through alb_co -> alb_ci.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    res_d    = res_q;
    zacc_d   = zacc_q;
    done_d   = 1'b0;
    result_d = result_q;
    co_d     = co_q;
    vo_d     = vo_q;
    no_d     = no_q;
    zo_d     = zo_q;
    nxt      = '0;
    alb_r_in = '0;
    alb_s_in = '0;
    alb_ci   = 1'b0;
    alb_i    = 2'b00;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          ci_d    = ci_in;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        alb_r_in = a_q[0];
        alb_s_in = b_q[0];
        alb_ci   = ci_q;
        alb_i    = op_q;
        idx_d    = '0;
        zacc_d   = 1'b1;
        state_d  = STEP;
      end

      STEP: begin
        alb_i         = op_q;
        res_d[idx_q]  = alb_f;
        zacc_d        = zacc_q & (alb_f == '0);
        if (idx_q != LAST) begin
          nxt      = idx_q + IDX_W'(1);
          alb_r_in = a_q[nxt];
          alb_s_in = b_q[nxt];
          alb_ci   = alb_co;
          idx_d    = nxt;
        end else begin
          result_d = res_d;
          co_d     = alb_co;
          vo_d     = alb_vo;
          no_d     = alb_f[NIB_W-1];
          zo_d     = zacc_d;
          done_d   = 1'b1;
          idx_d    = '0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_alb_word_seq.sv
// Directed bench for alb_word_seq driving a real alb slice at NIB=4.
module tb_alb_word_seq;

  localparam logic [1:0] T_OR   = 2'b00;
  localparam logic [1:0] T_ADD  = 2'b01;
  localparam logic [1:0] T_ANDN = 2'b10;
  localparam logic [1:0] T_SUB  = 2'b11;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        ci_in;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        co;
  logic        vo;
  logic        no;
  logic        zo;
  logic [3:0]  alb_r_in;
  logic [3:0]  alb_s_in;
  logic        alb_ci;
  logic [1:0]  alb_i;
  logic [3:0]  alb_f;
  logic        alb_co;
  logic        alb_vo;

  int total = 0;
  int bad   = 0;
  int lat;
  int extra;

  alb_word_seq #(.NIB(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .ci_in    (ci_in),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .co       (co),
    .vo       (vo),
    .no       (no),
    .zo       (zo),
    .alb_r_in (alb_r_in),
    .alb_s_in (alb_s_in),
    .alb_ci   (alb_ci),
    .alb_i    (alb_i),
    .alb_f    (alb_f),
    .alb_co   (alb_co),
    .alb_vo   (alb_vo)
  );

  alb u_alb (
    .clk     (clk),
    .reset_n (reset_n),
    .r_in    (alb_r_in),
    .s_in    (alb_s_in),
    .ci      (alb_ci),
    .i       (alb_i),
    .f_alb_c (alb_f),
    .co_c    (alb_co),
    .vo_c    (alb_vo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start; returns at the negedge of the cycle after acceptance.
  task automatic do_start(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic c);
    @(negedge clk);
    op    = o;
    a_in  = a;
    b_in  = b;
    ci_in = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges after acceptance until done is seen; bounded.
  task automatic wait_done(input int lat0, output int l);
    l = lat0;
    while (done !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic [15:0] er,
                        input logic eco, input logic evo, input logic eno, input logic ezo);
    int l;
    do_start(o, a, b, c);
    wait_done(1, l);
    check({tag, "_lat"}, 32'(l), 32'd6);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_co"}, 32'(co), 32'(eco));
    check({tag, "_vo"}, 32'(vo), 32'(evo));
    check({tag, "_no"}, 32'(no), 32'(eno));
    check({tag, "_zo"}, 32'(zo), 32'(ezo));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    a_in    = '0;
    b_in    = '0;
    ci_in   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({co, vo, no, zo}), 32'd0);
    check("rst_drive", 32'({alb_r_in, alb_s_in, alb_ci, alb_i}), 32'd0);
    reset_n = 1'b1;

    run_op("add_ovf",  T_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("add_rip",  T_ADD,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq",   T_SUB,  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sub_brw",  T_SUB,  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",  T_SUB,  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("or",       T_OR,   16'h0F0F, 16'hF000, 1'b0, 16'hFF0F, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("andn",     T_ANDN, 16'h00FF, 16'h0FF0, 1'b0, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start pulses while busy are ignored.
    do_start(T_ADD, 16'h0001, 16'h0002, 1'b0);
    check("busy_ready", 32'(ready), 32'd0);
    check("issue_drive", 32'({alb_r_in, alb_s_in, alb_ci, alb_i}), 32'({4'h1, 4'h2, 1'b0, T_ADD}));
    op    = T_SUB;
    a_in  = 16'h5555;
    b_in  = 16'h1111;
    ci_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat);
    check("ign_lat", 32'(lat), 32'd6);
    check("ign_res", 32'(result), 32'h0003);
    check("ign_co", 32'(co), 32'd0);
    count_dones(8, extra);
    check("ign_no_extra_done", 32'(extra), 32'd0);
    check("ign_res_held", 32'(result), 32'h0003);

    // Start in the done cycle is accepted immediately.
    do_start(T_ADD, 16'h1000, 16'h0234, 1'b0);
    wait_done(1, lat);
    check("bb1_lat", 32'(lat), 32'd6);
    check("bb1_res", 32'(result), 32'h1234);
    check("bb_ready_in_done", 32'(ready), 32'd1);
    op    = T_SUB;
    a_in  = 16'h0010;
    b_in  = 16'h0001;
    ci_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bb_done_low", 32'(done), 32'd0);
    check("bb_busy", 32'(ready), 32'd0);
    wait_done(1, lat);
    check("bb2_lat", 32'(lat), 32'd6);
    check("bb2_res", 32'(result), 32'h000F);
    check("bb2_co", 32'(co), 32'd1);

    // Reset while in STEP idx=2 abandons the operation.
    do_start(T_ADD, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_result", 32'(result), 32'd0);
    check("mrst_flags", 32'({co, vo, no, zo}), 32'd0);
    check("mrst_drive", 32'({alb_r_in, alb_s_in, alb_ci, alb_i}), 32'd0);
    count_dones(8, extra);
    check("mrst_no_done", 32'(extra), 32'd0);
    run_op("post_rst", T_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alb_word_seq.md
Name: alb_word_seq

Overview:
Multi-nibble sequencer for the 4-bit ALB slice. It accepts a word-wide operation through a start/done handshake and issues it to the ALB one nibble per cycle, least significant nibble first. It chains the ALB carry-out into the next nibble's carry-in and assembles the word result and word-level flags. It sits between the word-level datapath and a single `alb` instance, which keeps its own 1-cycle input-register latency.

Parameters:
NIB, 4, number of 4-bit nibbles per word; word width W = 4*NIB; legal range NIB >= 1
IDX_W, derived, nibble index width = max(1, clog2(NIB)); localparam, not overridable

Ports:
clk  in  1  clock; everything is posedge
reset_n  in  1  synchronous, active-low reset
start  in  1  request; accepted only when ready=1
op  in  2  ALB code: 00 OR, 01 ADD, 10 ANDN (~R&S), 11 SUB (R-S-1+CI)
a_in  in  W  operand R
b_in  in  W  operand S
ci_in  in  1  carry-in applied to nibble 0
ready  out  1  combinational; 1 iff state==IDLE
done  out  1  registered 1-cycle pulse; result and flags are valid from this cycle
result  out  W  word result; held until the next completion
co  out  1  word carry (ADD: carry out; SUB: 1 = no borrow; logic ops: 0)
vo  out  1  word signed overflow (ADD/SUB only, else 0)
no  out  1  result[W-1]
zo  out  1  result == 0
alb_r_in  out  4  to ALB R_in
alb_s_in  out  4  to ALB S_in
alb_ci  out  1  to ALB CI
alb_i  out  2  to ALB I
alb_f  in  4  from ALB F_ALB
alb_co  in  1  from ALB CO
alb_vo  in  1  from ALB VO

Behaviour:
- Reset (reset_n=0 at posedge):
  - state becomes IDLE; idx is cleared.
  - done, result, co, vo, no and zo are 0; ready=1.
  - Latched operands are cleared.
  - Takes effect even mid-operation: the operation is abandoned and no done is produced.
- ALB drive in IDLE: alb_r_in, alb_s_in, alb_ci and alb_i are all 0.
- State IDLE: on start=1, latch op, a_in, b_in and ci_in, then go to ISSUE. Otherwise stay.
- State ISSUE: drive nibble 0 (a[3:0], b[3:0], ci_lat, op_lat). Next state STEP with idx=0.
- State STEP, idx=k: the ALB outputs reflect nibble k.
  - Capture alb_f into res[4k+3:4k].
  - Accumulate a zero flag across nibbles.
  - If k < NIB-1: drive nibble k+1 with alb_ci = alb_co (a combinational pass-through), then idx=k+1.
  - If k == NIB-1: load result, co=alb_co, vo=alb_vo, no=alb_f[3] and zo=(accumulated zero flag AND alb_f==0). Pulse done and return to IDLE.
- Latency: done is high exactly NIB+2 cycles after the start-accept edge (6 cycles at NIB=4). Throughput is one operation per NIB+2 cycles.
- start while not IDLE is ignored; no queueing.
- start in the same cycle that done is high is accepted, because the state is already IDLE.
- op is constant for the whole operation; alb_i = op_lat in ISSUE and in STEP.
- Carry chaining is uniform for all ops. The ALB returns CO=0 for logic ops, so CI is don't-care there.
- Outputs change only at completion or reset; they are unaffected by ignored starts.

Decomposition:
- Shared package alb_pkg:
  - op codes OP_OR=2'b00, OP_ADD=2'b01, OP_ANDN=2'b10, OP_SUB=2'b11
  - nibble width constant NIB_W=4
  - sequencer state enum {IDLE, ISSUE, STEP}
- No sub-module: a single FSM with a nibble mux indexed by idx.
- The `alb` instance lives in the enclosing top, not inside this block.

Test Plan (bench instantiates alb_word_seq + alb, NIB=4):
- ADD a=0x7FFF b=0x0001 ci=0 -> result=0x8000 co=0 vo=1 no=1 zo=0; done exactly 6 cycles after accept.
- ADD a=0xFFFF b=0x0000 ci=1 -> result=0x0000 co=1 vo=0 zo=1 (full carry ripple through all nibbles).
- SUB ci=1, three cases:
  - 0x1234-0x1234 -> 0x0000 co=1 zo=1
  - 0x0000-0x0001 -> 0xFFFF co=0 no=1 vo=0
  - 0x8000-0x0001 -> 0x7FFF vo=1
- OR 0x0F0F|0xF000 -> 0xFF0F co=0 vo=0; ANDN a=0x00FF b=0x0FF0 -> 0x0F00 co=0 vo=0.
- start pulsed during ISSUE/STEP -> ignored, first result unchanged; start in the done cycle -> accepted, second done 6 cycles later.
- reset_n=0 during STEP idx=2 -> next cycle IDLE, ready=1, outputs 0, ALB drive 0, no done; then ADD 0x0001+0x0001 -> 0x0002.
